// File: rtl/adder_accumulator_pkg.sv
// adder_accumulator_pkg
// Shared definitions for the accumulation stage around adder_nbit.
//   state_t             : FSM state encoding (IDLE, ACCUM, DONE)
//   DEFAULT_NUM_BITS    : default operand/accumulator width
//   DEFAULT_NUM_SAMPLES : default number of operands per result
package adder_accumulator_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_NUM_BITS    = 4;
    localparam int DEFAULT_NUM_SAMPLES = 8;

endpackage

// File: rtl/adder_accumulator_if.sv
// adder_accumulator_if
// Operand stream and result handshake of the accumulation stage.
//   data_in/data_valid/data_ready : operand stream, transfer when valid && ready
//   sum_out/sum_valid/sum_ack     : result, held until sum_ack while sum_valid
//   overflow_flag                 : sticky carry-out indicator for the run
// Modports: master = producer/consumer side, slave = adder_accumulator.
//
// Handshake semantics: an operand transfers on a rising clk edge where
// data_valid and data_ready are both 1; data_ready depends only on the
// block's state, never on data_valid. A result is taken on the rising edge
// where sum_valid and sum_ack are both 1; sum_out is stable meanwhile.
interface adder_accumulator_if
    import adder_accumulator_pkg::*;
#(
    parameter int NUM_BITS = DEFAULT_NUM_BITS
);
    logic [NUM_BITS-1:0] data_in;
    logic                data_valid;
    logic                data_ready;
    logic                sum_ack;
    logic [NUM_BITS-1:0] sum_out;
    logic                sum_valid;
    logic                overflow_flag;

    modport master (
        output data_in, data_valid, sum_ack,
        input  data_ready, sum_out, sum_valid, overflow_flag
    );

    modport slave (
        input  data_in, data_valid, sum_ack,
        output data_ready, sum_out, sum_valid, overflow_flag
    );
endinterface

// File: rtl/adder_accumulator_adder_nbit.sv
// adder_nbit
// Combinational NUM_BITS ripple adder.
//   a, b     : operands
//   carry_in : carry into bit 0
//   sum      : a + b + carry_in modulo 2^NUM_BITS
//   overflow : carry out of the top bit
module adder_nbit #(
    parameter int NUM_BITS = 4
) (
    input  logic [NUM_BITS-1:0] a,
    input  logic [NUM_BITS-1:0] b,
    input  logic                carry_in,
    output logic [NUM_BITS-1:0] sum,
    output logic                overflow
);
    assign {overflow, sum} = {1'b0, a} + {1'b0, b} + {{NUM_BITS{1'b0}}, carry_in};
endmodule

// File: rtl/adder_accumulator.sv
// adder_accumulator
// Adds NUM_SAMPLES accepted operands into a running register using one
// adder_nbit instance, tracks a sticky overflow and presents the total
// through a valid/ack handshake.
//   clk       : rising-edge clock
//   n_rst     : asynchronous active-low reset
//   clear     : synchronous abort back to IDLE (highest priority)
//   bus       : adder_accumulator_if.slave (operand stream + result)
//   state_dbg : current FSM state, for observation only
// Build option: SATURATE_EN -- when defined, the accumulator loads all-ones
// on the first carry out of a run and stays there until the run ends.
module adder_accumulator
    import adder_accumulator_pkg::*;
#(
    parameter int NUM_BITS    = DEFAULT_NUM_BITS,
    parameter int NUM_SAMPLES = DEFAULT_NUM_SAMPLES
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  clear,
    adder_accumulator_if.slave    bus,
    output state_t                state_dbg
);
    localparam int CW = $clog2(NUM_SAMPLES + 1);

    state_t              state_q, state_d;
    logic [NUM_BITS-1:0] acc_q, acc_d;
    logic [CW-1:0]       count_q, count_d;
    logic                ovf_q, ovf_d;

    logic [NUM_BITS-1:0] add_sum;
    logic                add_ovf;
    logic                accept;
    logic                last_sample;

    adder_nbit #(.NUM_BITS(NUM_BITS)) u_adder (
        .a        (acc_q),
        .b        (bus.data_in),
        .carry_in (1'b0),
        .sum      (add_sum),
        .overflow (add_ovf)
    );

    assign bus.data_ready    = (state_q != DONE);
    assign bus.sum_valid     = (state_q == DONE);
    assign bus.sum_out       = acc_q;
    assign bus.overflow_flag = ovf_q;
    assign state_dbg         = state_q;

    assign accept      = bus.data_valid && bus.data_ready;
    // The current accept is the last one when NUM_SAMPLES-1 are already in.
    assign last_sample = (count_q == CW'(NUM_SAMPLES - 1));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;

        if (clear) begin
            state_d = IDLE;
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    if (accept) begin
`ifdef SATURATE_EN
                        if (add_ovf || ovf_q) begin
                            acc_d = '1;
                        end else begin
                            acc_d = add_sum;
                        end
`else
                        acc_d = add_sum;
`endif
                        count_d = count_q + CW'(1);
                        ovf_d   = ovf_q | add_ovf;
                        state_d = last_sample ? DONE : ACCUM;
                    end
                end
                DONE: begin
                    if (bus.sum_ack) begin
                        state_d = IDLE;
                        acc_d   = '0;
                        count_d = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    acc_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            endcase
        end
    end
endmodule
